// File: rtl/alu_op_sequencer_if.sv
// alu_op_sequencer_if: operand/result bus between the sequencer and a combinational jALU
interface alu_op_sequencer_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] bas;
    logic [WIDTH-1:0] bbs;
    logic             wci;
    logic [2:0]       bops;
    logic [WIDTH-1:0] bcs;
    logic             wco;
    logic             weqo;
    logic             walo;
    logic             wz;
    modport master (output bas, bbs, wci, bops, input bcs, wco, weqo, walo, wz);
    modport slave  (input bas, bbs, wci, bops, output bcs, wco, weqo, walo, wz);
endinterface

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: runs one ALU instruction through TMP load, execute and write-back steps
module alu_op_sequencer #(
    parameter int WIDTH = 8,
    parameter int NREG  = 4
) (
    input  logic               wclk,
    input  logic               wreset,
    input  logic               wstart,
    input  logic [7:0]         binstr,
    input  logic               wld,
    input  logic [1:0]         bldsel,
    input  logic [WIDTH-1:0]   bldval,
    input  logic [1:0]         brdsel,
    output logic [WIDTH-1:0]   brd,
    alu_op_sequencer_if.master alu,
    output logic [WIDTH-1:0]   bacc,
    output logic [3:0]         bflags,
    output logic               wbusy,
    output logic               wdone
);
    localparam logic [1:0] IDLE = 2'd0, LOADB = 2'd1, EXEC = 2'd2, WRITE = 2'd3;
    localparam logic [2:0] OP_CMP = 3'b111;
    logic [1:0]       state;
    logic [6:0]       instr;
    logic [WIDTH-1:0] tmp;
    logic [WIDTH-1:0] breg [NREG];
    logic [2:0]       op;
    logic [1:0]       ra;
    logic [1:0]       rb;
    assign op    = instr[6:4];
    assign ra    = instr[3:2];
    assign rb    = instr[1:0];
    assign brd   = breg[brdsel];
    assign wbusy = state != IDLE;
    // jALU inputs are live only in EXEC; elsewhere park them with no result enabler selected
    always_comb begin
        alu.bas  = state == EXEC ? breg[ra] : '0;
        alu.bbs  = state == EXEC ? tmp : '0;
        alu.wci  = state == EXEC ? bflags[3] : 1'b0;
        alu.bops = state == EXEC ? op : OP_CMP;
    end
    // sequencer state, register file, TMP, accumulator, flags and completion pulse
    always_ff @(posedge wclk) begin
        if (wreset) begin
            state  <= IDLE;
            instr  <= '0;
            tmp    <= '0;
            bacc   <= '0;
            bflags <= '0;
            wdone  <= 1'b0;
            for (int i = 0; i < NREG; i++) breg[i] <= '0;
        end else begin
            wdone <= 1'b0;
            case (state)
                IDLE: begin
                    if (wld) begin
                        breg[bldsel] <= bldval;
                    end else if (wstart && binstr[7]) begin
                        instr <= binstr[6:0];
                        state <= LOADB;
                    end
                end
                LOADB: begin
                    tmp   <= breg[rb];
                    state <= EXEC;
                end
                EXEC: begin
                    bacc   <= alu.bcs;
                    bflags <= {alu.wco, alu.walo, alu.weqo, alu.wz};
                    state  <= WRITE;
                end
                default: begin
                    if (op != OP_CMP) breg[rb] <= bacc;
                    wdone <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: randomized scoreboard bench pairing the sequencer with a behavioural jALU
module tb_alu_op_sequencer;
    typedef struct packed {
        logic [7:0] cs;
        logic       co;
        logic       alo;
        logic       eq;
        logic       z;
    } alu_res_t;
    typedef struct {
        int         cyc;
        logic [7:0] acc;
        logic [3:0] flags;
        logic [7:0] wb;
    } exp_t;

    logic       clk = 1'b0;
    logic       wreset = 1'b1;
    logic       wstart = 1'b0;
    logic [7:0] binstr = '0;
    logic       wld = 1'b0;
    logic [1:0] bldsel = '0;
    logic [7:0] bldval = '0;
    logic [1:0] brdsel = '0;
    logic [7:0] brd;
    logic [7:0] bacc;
    logic [3:0] bflags;
    logic       wbusy;
    logic       wdone;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    exp_t sbq[$];
    logic [7:0] mreg [4];
    logic [3:0] mflags;

    alu_op_sequencer_if bus ();

    alu_op_sequencer dut (
        .wclk   (clk),
        .wreset (wreset),
        .wstart (wstart),
        .binstr (binstr),
        .wld    (wld),
        .bldsel (bldsel),
        .bldval (bldval),
        .brdsel (brdsel),
        .brd    (brd),
        .alu    (bus),
        .bacc   (bacc),
        .bflags (bflags),
        .wbusy  (wbusy),
        .wdone  (wdone)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // jALU behaviour: compare outputs only for CMP, carry only for ADD/SHR/SHL
    function automatic alu_res_t alu_ref(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op, input logic ci);
        alu_res_t r;
        int s;
        r = '0;
        s = 0;
        case (op)
            3'd0: begin s = int'(a) + int'(b) + int'(ci); r.cs = 8'(s); r.co = s > 255; end
            3'd1: begin r.cs = 8'((int'(a) / 2) + (ci ? 128 : 0)); r.co = a[0]; end
            3'd2: begin s = int'(a) * 2 + int'(ci); r.cs = 8'(s); r.co = s > 255; end
            3'd3: r.cs = 8'(255 - int'(a));
            3'd4: r.cs = a & b;
            3'd5: r.cs = a | b;
            3'd6: r.cs = a ^ b;
            default: begin r.eq = a == b; r.alo = a > b; end
        endcase
        r.z = r.cs == 8'd0;
        return r;
    endfunction

    alu_res_t stub;
    always_comb begin
        stub     = alu_ref(bus.bas, bus.bbs, bus.bops, bus.wci);
        bus.bcs  = stub.cs;
        bus.wco  = stub.co;
        bus.walo = stub.alo;
        bus.weqo = stub.eq;
        bus.wz   = stub.z;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // monitor: every completion pulse must match the oldest outstanding instruction
    always @(negedge clk) begin
        if (wdone) begin
            if (sbq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_wdone actual=1 expected=0 at cycle %0d", cyc);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                check("done_cycle", cyc, e.cyc);
                check("acc", bacc, e.acc);
                check("flags", bflags, e.flags);
                check("writeback", brd, e.wb);
            end
        end
    end

    task automatic do_reset();
        wreset = 1'b1;
        @(posedge clk); #1;
        wreset = 1'b0;
        for (int i = 0; i < 4; i++) mreg[i] = '0;
        mflags = '0;
        check("rst_busy", wbusy, 0);
        check("rst_done", wdone, 0);
        check("rst_acc", bacc, 0);
        check("rst_flags", bflags, 0);
        check("rst_bops", bus.bops, 3'b111);
        check("rst_bas", bus.bas, 0);
        for (int i = 0; i < 4; i++) begin
            brdsel = 2'(i);
            #1;
            check("rst_reg", brd, 0);
        end
    endtask

    task automatic load(input logic [1:0] r, input logic [7:0] v, input bit with_start);
        wld = 1'b1; bldsel = r; bldval = v; wstart = with_start; binstr = 8'h81;
        @(posedge clk); #1;
        mreg[r] = v;
        wld = 1'b0; wstart = 1'b0;
        if (with_start) check("ld_over_start_busy", wbusy, 0);
    endtask

    task automatic read_reg(input logic [1:0] r);
        @(posedge clk); #1;
        brdsel = r;
        #1;
        check("brd", brd, mreg[r]);
    endtask

    task automatic illegal_start(input logic [6:0] low);
        wstart = 1'b1; binstr = {1'b0, low};
        @(posedge clk); #1;
        wstart = 1'b0;
        check("non_alu_ignored", wbusy, 0);
    endtask

    task automatic run_instr(input logic [7:0] ins, input bit noise);
        logic [2:0] op;
        logic [1:0] ra;
        logic [1:0] rb;
        logic [7:0] ea;
        logic [7:0] eb;
        logic       eci;
        alu_res_t   r;
        exp_t       e;
        op = ins[6:4]; ra = ins[3:2]; rb = ins[1:0];
        ea = mreg[ra]; eb = mreg[rb]; eci = mflags[3];
        r = alu_ref(ea, eb, op, eci);
        e.cyc = cyc + 4;
        e.acc = r.cs;
        e.flags = {r.co, r.alo, r.eq, r.z};
        mflags = e.flags;
        if (op != 3'b111) mreg[rb] = r.cs;
        e.wb = mreg[rb];
        sbq.push_back(e);
        wstart = 1'b1; binstr = ins; wld = 1'b0;
        @(posedge clk); #1;
        for (int k = 0; k < 3; k++) begin
            check("busy", wbusy, 1);
            if (k == 0) check("loadb_bops_idle", bus.bops, 3'b111);
            if (k == 1) begin
                check("exec_bas", bus.bas, ea);
                check("exec_bbs", bus.bbs, eb);
                check("exec_wci", bus.wci, eci);
                check("exec_bops", bus.bops, op);
            end
            if (k == 2) brdsel = rb;
            wstart = noise; binstr = 8'($urandom);
            wld = noise; bldsel = 2'($urandom); bldval = 8'($urandom);
            @(posedge clk); #1;
        end
        wstart = 1'b0; wld = 1'b0;
        check("idle_at_done", wbusy, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        do_reset();
        load(2'd0, 8'h05, 0); load(2'd1, 8'h03, 0);
        run_instr(8'h81, 0);
        check("t1_flags", bflags, 4'b0000);
        read_reg(2'd1); check("t1_r1", brd, 8'h08);
        load(2'd0, 8'hFF, 0); load(2'd1, 8'h01, 0);
        run_instr(8'h81, 0);
        check("t2_flags", bflags, 4'b1001);
        load(2'd2, 8'h00, 0); load(2'd3, 8'h00, 0);
        run_instr(8'h8B, 0);
        read_reg(2'd3); check("t2_carry_in", brd, 8'h01);
        load(2'd2, 8'h10, 0); load(2'd3, 8'h10, 0);
        run_instr(8'hFB, 0);
        check("t3_cmp_eq", bflags, 4'b0011);
        load(2'd2, 8'h20, 0);
        run_instr(8'hFB, 0);
        check("t3_cmp_gt", bflags, 4'b0101);
        read_reg(2'd3); check("t3_no_wb", brd, 8'h10);
        run_instr(8'h81, 1);
        illegal_start(7'h41);
        repeat (5) @(posedge clk);
        #1;
        load(2'd0, 8'h11, 0); load(2'd1, 8'h22, 0);
        wstart = 1'b1; binstr = 8'h81;
        @(posedge clk); #1;
        wstart = 1'b0;
        @(posedge clk); #1;
        check("t5_in_exec_bops", bus.bops, 3'b000);
        do_reset();
        repeat (6) @(posedge clk);
        #1;
        load(2'd0, 8'hA5, 0); load(2'd1, 8'hA5, 0);
        run_instr(8'hB1, 0);
        read_reg(2'd1); check("t6_not", brd, 8'h5A);
        load(2'd2, 8'h77, 1);
        read_reg(2'd2); check("t6_ld_priority", brd, 8'h77);
        repeat (5) @(posedge clk);
        #1;
        run_instr(8'h81, 0);
        run_instr(8'hA6, 0);
        for (int n = 0; n < 300; n++) begin
            case ($urandom_range(0, 9))
                0, 1, 2: load(2'($urandom), 8'($urandom), $urandom_range(0, 3) == 0);
                3: read_reg(2'($urandom));
                4: illegal_start(7'($urandom));
                default: run_instr({1'b1, 7'($urandom)}, $urandom_range(0, 1) == 1);
            endcase
        end
        repeat (6) @(posedge clk);
        #1;
        check("scoreboard_empty", sbq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
